// File: rtl/free_list_nport.sv
// N-port physical-register free list: compacted multi-port allocate, multi-port release,
// and read-pointer checkpoints for single-cycle misprediction recovery.
module free_list_nport #(
    parameter int DEPTH      = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int NUM_PORTS  = 3,
    parameter int NUM_CKPT   = 4,
    parameter int RESET_BASE = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(NUM_CKPT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           alloc_req,
    output logic [NUM_PORTS*TAG_WIDTH-1:0] alloc_tag,
    output logic [NUM_PORTS-1:0]           alloc_valid,
    input  logic [NUM_PORTS-1:0]           rel_en,
    input  logic [NUM_PORTS*TAG_WIDTH-1:0] rel_tag,
    input  logic                           ckpt_save,
    input  logic [CW-1:0]                  ckpt_save_id,
    input  logic                           ckpt_restore,
    input  logic [CW-1:0]                  ckpt_restore_id,
    output logic [AW:0]                    count,
    output logic                           empty,
    output logic                           full,
    output logic                           can_alloc_all,
    output logic                           error_o
);

    localparam logic [AW+1:0] DEPTH_X = (AW+2)'(DEPTH);

    logic [TAG_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]          slot_q [NUM_CKPT];
    logic [NUM_CKPT-1:0]  ckpt_valid;
    logic [AW:0]          rd_ptr, wr_ptr, rd_next, wr_next;
    logic                 err_q;

    logic [AW+1:0]        cnt_x;
    logic [AW:0]          r_cnt, w_cnt, n_grant, n_accept, fill_after;
    logic [AW-1:0]        rd_idx;
    logic [NUM_PORTS-1:0] wr_en;
    logic [AW-1:0]        wr_idx [NUM_PORTS];
    logic                 rel_drop, restore_err, save_en;

    assign count         = wr_ptr - rd_ptr;
    assign cnt_x         = {1'b0, count};
    assign empty         = (count == '0);
    assign full          = (cnt_x == DEPTH_X);
    assign can_alloc_all = (cnt_x >= (AW+2)'(NUM_PORTS));
    assign error_o       = err_q;

    // r_cnt counts requesting ports, so an idle port 0 lets port 1 take the head entry
    always_comb begin
        alloc_valid = '0;
        alloc_tag   = '0;
        n_grant     = '0;
        r_cnt       = '0;
        rd_idx      = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (alloc_req[k]) begin
                if ((r_cnt < count) && !ckpt_restore) begin
                    rd_idx                                 = rd_ptr[AW-1:0] + r_cnt[AW-1:0];
                    alloc_valid[k]                         = 1'b1;
                    alloc_tag[k*TAG_WIDTH +: TAG_WIDTH]    = mem[rd_idx];
                    n_grant                                = n_grant + 1'b1;
                end
                r_cnt = r_cnt + 1'b1;
            end
        end
    end

    // Drops form a suffix of enabled ports, so w_cnt equals the accepted count for accepted ports
    always_comb begin
        wr_en    = '0;
        n_accept = '0;
        w_cnt    = '0;
        rel_drop = 1'b0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            wr_idx[k] = wr_ptr[AW-1:0] + w_cnt[AW-1:0];
            if (rel_en[k]) begin
                if ((cnt_x + {1'b0, w_cnt}) < DEPTH_X) begin
                    wr_en[k] = 1'b1;
                    n_accept = n_accept + 1'b1;
                end else begin
                    rel_drop = 1'b1;
                end
                w_cnt = w_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        wr_next     = wr_ptr + n_accept;
        rd_next     = rd_ptr + n_grant;
        restore_err = 1'b0;
        save_en     = ckpt_save && !ckpt_restore;
        if (ckpt_restore) begin
            if (ckpt_valid[ckpt_restore_id]) begin
                rd_next = slot_q[ckpt_restore_id];
            end else begin
                restore_err = 1'b1;
            end
        end
        fill_after = wr_next - rd_next;
        if (ckpt_restore && ckpt_valid[ckpt_restore_id] && ({1'b0, fill_after} > DEPTH_X)) begin
            restore_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= (AW+1)'(DEPTH);
            ckpt_valid <= '0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= TAG_WIDTH'(RESET_BASE + i);
            end
            for (int unsigned c = 0; c < NUM_CKPT; c++) begin
                slot_q[c] <= '0;
            end
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_next;
            err_q  <= rel_drop | restore_err;
            if (save_en) begin
                slot_q[ckpt_save_id]     <= rd_next;
                ckpt_valid[ckpt_save_id] <= 1'b1;
            end
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                if (wr_en[k]) begin
                    mem[wr_idx[k]] <= rel_tag[k*TAG_WIDTH +: TAG_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_free_list_nport.sv
// Directed bench for free_list_nport: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_free_list_nport;

    localparam int DEPTH = 32;
    localparam int TW    = 6;
    localparam int NP    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  alloc_req, alloc_valid, rel_en;
    logic [17:0] alloc_tag, rel_tag;
    logic        ckpt_save, ckpt_restore;
    logic [1:0]  ckpt_save_id, ckpt_restore_id;
    logic [5:0]  count;
    logic        empty, full, can_alloc_all, error_o;

    always #5 clk = ~clk;

    free_list_nport #(
        .DEPTH(32),
        .TAG_WIDTH(6),
        .NUM_PORTS(3),
        .NUM_CKPT(4),
        .RESET_BASE(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alloc_req(alloc_req),
        .alloc_tag(alloc_tag),
        .alloc_valid(alloc_valid),
        .rel_en(rel_en),
        .rel_tag(rel_tag),
        .ckpt_save(ckpt_save),
        .ckpt_save_id(ckpt_save_id),
        .ckpt_restore(ckpt_restore),
        .ckpt_restore_id(ckpt_restore_id),
        .count(count),
        .empty(empty),
        .full(full),
        .can_alloc_all(can_alloc_all),
        .error_o(error_o)
    );

    typedef struct {
        logic [2:0]  v;
        logic [17:0] tags;
        int          cnt;
        logic        err;
    } rec_t;

    rec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [17:0] t3(input int a, input int b, input int c);
        logic [5:0] x, y, z;
        x = 6'(a);
        y = 6'(b);
        z = 6'(c);
        return {z, y, x};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        rec_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("alloc_valid", int'(alloc_valid), int'(e.v));
            chk("count", int'(count), e.cnt);
            chk("error_o", int'(error_o), int'(e.err));
            chk("empty", int'(empty), int'(e.cnt == 0));
            chk("full", int'(full), int'(e.cnt == DEPTH));
            chk("can_alloc_all", int'(can_alloc_all), int'(e.cnt >= NP));
            for (int k = 0; k < NP; k++) begin
                chk($sformatf("alloc_tag%0d", k), int'(alloc_tag[k*TW +: TW]), int'(e.tags[k*TW +: TW]));
            end
        end
    end

    task automatic cyc(input logic [2:0] req, input logic [2:0] ren, input logic [17:0] rt,
                       input logic sv, input logic [1:0] sid, input logic rs, input logic [1:0] rid,
                       input logic [2:0] ev, input logic [17:0] et, input int ec, input logic ee);
        rec_t r;
        alloc_req       = req;
        rel_en          = ren;
        rel_tag         = rt;
        ckpt_save       = sv;
        ckpt_save_id    = sid;
        ckpt_restore    = rs;
        ckpt_restore_id = rid;
        r.v    = ev;
        r.tags = et;
        r.cnt  = ec;
        r.err  = ee;
        sb.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [2:0] req, input logic [2:0] ev, input logic [17:0] et,
                         input int ec, input logic ee);
        cyc(req, 3'b000, '0, 1'b0, 2'd0, 1'b0, 2'd0, ev, et, ec, ee);
    endtask

    task automatic idle(input int ec, input logic ee);
        cyc(3'b000, 3'b000, '0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, '0, ec, ee);
    endtask

    // Reset asserted with hostile inputs: they must be ignored and error_o must stay low
    task automatic do_reset();
        rst             = 1'b1;
        alloc_req       = 3'b111;
        rel_en          = 3'b111;
        rel_tag         = '1;
        ckpt_save       = 1'b1;
        ckpt_save_id    = 2'd3;
        ckpt_restore    = 1'b1;
        ckpt_restore_id = 2'd3;
        @(posedge clk);
        #1;
        rst             = 1'b0;
        alloc_req       = '0;
        rel_en          = '0;
        rel_tag         = '0;
        ckpt_save       = 1'b0;
        ckpt_save_id    = '0;
        ckpt_restore    = 1'b0;
        ckpt_restore_id = '0;
    endtask

    initial begin
        rst             = 1'b1;
        alloc_req       = '0;
        rel_en          = '0;
        rel_tag         = '0;
        ckpt_save       = 1'b0;
        ckpt_save_id    = '0;
        ckpt_restore    = 1'b0;
        ckpt_restore_id = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // full-width allocation twice
        alloc(3'b111, 3'b111, t3(32, 33, 34), 32, 1'b0);
        alloc(3'b111, 3'b111, t3(35, 36, 37), 29, 1'b0);
        idle(26, 1'b0);

        // compaction: idle port 0
        do_reset();
        alloc(3'b110, 3'b110, t3(0, 32, 33), 32, 1'b0);
        idle(30, 1'b0);

        // drain, partial grant, empty with same-cycle release, then reuse
        do_reset();
        for (int i = 0; i < 10; i++) begin
            alloc(3'b111, 3'b111, t3(32 + 3*i, 33 + 3*i, 34 + 3*i), 32 - 3*i, 1'b0);
        end
        alloc(3'b111, 3'b011, t3(62, 63, 0), 2, 1'b0);
        cyc(3'b111, 3'b001, t3(40, 0, 0), 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, '0, 0, 1'b0);
        alloc(3'b001, 3'b001, t3(40, 0, 0), 1, 1'b0);
        idle(0, 1'b0);

        // out-of-order release and wrap-around
        do_reset();
        alloc(3'b111, 3'b111, t3(32, 33, 34), 32, 1'b0);
        cyc(3'b000, 3'b101, t3(34, 0, 32), 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, '0, 29, 1'b0);
        for (int i = 0; i < 29; i++) begin
            alloc(3'b001, 3'b001, t3(35 + i, 0, 0), 31 - i, 1'b0);
        end
        alloc(3'b001, 3'b001, t3(34, 0, 0), 2, 1'b0);
        alloc(3'b001, 3'b001, t3(32, 0, 0), 1, 1'b0);
        idle(0, 1'b0);

        // checkpoint save / restore, save-vs-restore priority, invalid slot
        do_reset();
        cyc(3'b111, 3'b000, '0, 1'b1, 2'd2, 1'b0, 2'd0, 3'b111, t3(32, 33, 34), 32, 1'b0);
        alloc(3'b111, 3'b111, t3(35, 36, 37), 29, 1'b0);
        alloc(3'b111, 3'b111, t3(38, 39, 40), 26, 1'b0);
        cyc(3'b111, 3'b000, '0, 1'b0, 2'd0, 1'b1, 2'd2, 3'b000, '0, 23, 1'b0);
        alloc(3'b001, 3'b001, t3(35, 0, 0), 29, 1'b0);
        cyc(3'b000, 3'b000, '0, 1'b1, 2'd1, 1'b1, 2'd2, 3'b000, '0, 28, 1'b0);
        cyc(3'b111, 3'b000, '0, 1'b0, 2'd0, 1'b1, 2'd1, 3'b000, '0, 29, 1'b0);
        idle(29, 1'b1);
        idle(29, 1'b0);

        // release into a full list, restore of a never-saved slot
        do_reset();
        cyc(3'b000, 3'b001, t3(5, 0, 0), 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, '0, 32, 1'b0);
        idle(32, 1'b1);
        cyc(3'b000, 3'b000, '0, 1'b0, 2'd0, 1'b1, 2'd3, 3'b000, '0, 32, 1'b0);
        alloc(3'b001, 3'b001, t3(32, 0, 0), 32, 1'b1);
        idle(31, 1'b0);

        chk("scoreboard_left", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
